// File: rtl/muldiv_ctrl.sv
// Multiply/divide unit controller for a MIPS-style pipeline.
// It owns the HI/LO architectural registers and models a multi-cycle mult/div
// latency with a down-counter. While an operation runs it reports busy. It also
// raises a stall request when the ID-stage instruction needs the unit.
module muldiv_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use_D,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t MULT_LOAD = cnt_t'(MULT_CYCLES);
  localparam cnt_t DIV_LOAD  = cnt_t'(DIV_CYCLES);
  localparam cnt_t CNT_ONE   = cnt_t'(1);

  // Operation encodings on the op input. Values 6 and 7 are reserved and do nothing.
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        signed_q, signed_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Results from the latched operands. The multiplier extends both operands to
  // 64 bits, using sign or zero extension to match the latched signedness.
  // The low 64 bits of that product are then correct for both mult and multu.
  logic [63:0] a_ext, b_ext, product;
  logic [31:0] b_safe;
  logic [31:0] quot, rem;
  logic        last_cycle;

  // Combinational datapath: the product and the quotient/remainder of the held operands.
  always_comb begin
    a_ext   = signed_q ? {{32{a_q[31]}}, a_q} : {32'h0, a_q};
    b_ext   = signed_q ? {{32{b_q[31]}}, b_q} : {32'h0, b_q};
    product = a_ext * b_ext;
    // A zero divisor is replaced by 1 only to keep the divider free of X.
    // Its result is never written to HI/LO.
    b_safe  = (b_q == 32'h0) ? 32'h1 : b_q;
    if (signed_q) begin
      quot = 32'($signed(a_q) / $signed(b_safe));
      rem  = 32'($signed(a_q) % $signed(b_safe));
    end else begin
      quot = a_q / b_safe;
      rem  = a_q % b_safe;
    end
  end

  // The edge that takes the counter from 1 to 0 is the completion edge.
  assign last_cycle = (cnt_q <= CNT_ONE);

  // Next-state logic: accept commands in IDLE, count down, and commit results at completion.
  always_comb begin
    // NOTE: every target gets a default first. That way no path through the
    // case statements leaves a signal unassigned, and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              a_d      = A;
              b_d      = B;
              signed_d = (op == OP_MULT);
              cnt_d    = MULT_LOAD;
              state_d  = MUL;
            end
            OP_DIV, OP_DIVU: begin
              a_d      = A;
              b_d      = B;
              signed_d = (op == OP_DIV);
              cnt_d    = DIV_LOAD;
              state_d  = DIV;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;  // reserved encodings leave everything untouched
          endcase
        end
      end

      MUL: begin
        if (last_cycle) begin
          hi_d    = product[63:32];
          lo_d    = product[31:0];
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      DIV: begin
        if (last_cycle) begin
          // Division by zero still uses the full busy time but leaves HI/LO as they were.
          if (b_q != 32'h0) begin
            hi_d = rem;
            lo_d = quot;
          end
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and data registers with an asynchronous reset that aborts any operation in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the operand registers are ordinary flops, not a memory array.
      // They are cleared along with the rest, so a reset leaves no stale operands behind.
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the values from before the edge.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign md_stall = md_use_D & (start | busy);
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl, which runs with its default latencies (5 and 10).
module tb_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_use_D;
  logic        busy;
  logic        md_stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .md_use_D (md_use_D),
    .busy     (busy),
    .md_stall (md_stall),
    .HI       (HI),
    .LO       (LO)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one command for one rising edge, then drop start.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count consecutive busy cycles, sampled on falling edges.
  // Returns at the first idle cycle, or when the cycle budget runs out.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", HI); end
    checks++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", LO); end
    md_use_D = 1'b1;
    #1;
    checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle: got %b want 0", md_stall); end
    start = 1'b1;
    #1;
    checks++; if (md_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_start: got %b want 1", md_stall); end
    start    = 1'b0;
    md_use_D = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mult_signed;
    int n;
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    count_busy(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 5", n); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
    checks++; if (LO !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo: got %h want fffffff1", LO); end
  endtask

  task automatic test_divu;
    int n;
    issue(3'd3, 32'd100, 32'd7);
    count_busy(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL divu_busy_cycles: got %0d want 10", n); end
    checks++; if (LO !== 32'h0000_000E) begin errors++; $display("FAIL divu_lo: got %h want 0000000e", LO); end
    checks++; if (HI !== 32'h0000_0002) begin errors++; $display("FAIL divu_hi: got %h want 00000002", HI); end
  endtask

  task automatic test_div_signed;
    int n;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL div_busy_cycles: got %0d want 10", n); end
    checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", LO); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", HI); end
  endtask

  task automatic test_div_by_zero;
    int n;
    issue(3'd4, 32'h11, 32'h0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", busy); end
    checks++; if (HI !== 32'h11) begin errors++; $display("FAIL mthi_value: got %h want 00000011", HI); end
    issue(3'd5, 32'h22, 32'h0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b want 0", busy); end
    checks++; if (LO !== 32'h22) begin errors++; $display("FAIL mtlo_value: got %h want 00000022", LO); end
    issue(3'd2, 32'd1234, 32'd0);
    count_busy(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL div0_busy_cycles: got %0d want 10", n); end
    checks++; if (HI !== 32'h11) begin errors++; $display("FAIL div0_hi: got %h want 00000011", HI); end
    checks++; if (LO !== 32'h22) begin errors++; $display("FAIL div0_lo: got %h want 00000022", LO); end
  endtask

  task automatic test_reserved_op;
    issue(3'd6, 32'hDEAD_BEEF, 32'h1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rsv6_busy: got %b want 0", busy); end
    issue(3'd7, 32'hCAFE_F00D, 32'h1);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rsv7_busy: got %b want 0", busy); end
    checks++; if (HI !== 32'h11) begin errors++; $display("FAIL rsv_hi: got %h want 00000011", HI); end
    checks++; if (LO !== 32'h22) begin errors++; $display("FAIL rsv_lo: got %h want 00000022", LO); end
  endtask

  task automatic test_start_while_busy;
    int n;
    md_use_D = 1'b1;
    issue(3'd1, 32'd3, 32'd4);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      checks++; if (md_stall !== 1'b1) begin errors++; $display("FAIL busy_stall cycle %0d: got %b want 1", n, md_stall); end
      checks++; if (LO !== 32'h22) begin errors++; $display("FAIL busy_lo_hold cycle %0d: got %h want 00000022", n, LO); end
      if (n == 2) begin
        start = 1'b1;
        op    = 3'd5;
        A     = 32'h55;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    checks++; if (n !== 5) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 5", n); end
    checks++; if (LO !== 32'd12) begin errors++; $display("FAIL multu_lo: got %h want 0000000c", LO); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL multu_hi: got %h want 00000000", HI); end
    checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL idle_stall: got %b want 0", md_stall); end
    md_use_D = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    int n;
    issue(3'd3, 32'd100, 32'd7);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy) n++;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL pre_abort_busy: got %0d want 4", n); end
    rst      = 1'b1;
    md_use_D = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL abort_hi: got %h want 00000000", HI); end
    checks++; if (LO !== 32'h0) begin errors++; $display("FAIL abort_lo: got %h want 00000000", LO); end
    checks++; if (dut.state_q !== 2'd0) begin errors++; $display("FAIL abort_state: got %0d want 0", dut.state_q); end
    checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL abort_stall: got %b want 0", md_stall); end
    md_use_D = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (HI !== 32'h0 || LO !== 32'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_resume: got busy=%b hi=%h lo=%h want 0/0/0", busy, HI, LO);
    end
    issue(3'd0, 32'd2, 32'd3);
    count_busy(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL post_rst_busy: got %0d want 5", n); end
    checks++; if (LO !== 32'd6) begin errors++; $display("FAIL post_rst_lo: got %h want 00000006", LO); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL post_rst_hi: got %h want 00000000", HI); end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    op       = 3'd0;
    A        = 32'h0;
    B        = 32'h0;
    md_use_D = 1'b0;
    test_reset();
    test_mult_signed();
    test_divu();
    test_div_signed();
    test_div_by_zero();
    test_reserved_op();
    test_start_while_busy();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, meaning the number of busy cycles for mult/multu.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, meaning the number of busy cycles for div/divu.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: the EX-stage instruction is a mult/div/mthi/mtlo; sampled at the clock edge.
REQ-006 The block SHALL have port op, input, 3 bits: operation select; 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 reserved.
REQ-007 The block SHALL have port A, input, 32 bits: rs operand (forwarded EX value).
REQ-008 The block SHALL have port B, input, 32 bits: rt operand (forwarded EX value).
REQ-009 The block SHALL have port md_use_D, input, 1 bit: the ID-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-011 The block SHALL have port md_stall, output, 1 bit: stall request to the hazard logic.
REQ-012 The block SHALL have port HI, output, 32 bits: architectural HI register.
REQ-013 The block SHALL have port LO, output, 32 bits: architectural LO register.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, MUL and DIV, a down-counter sized for max(MULT_CYCLES, DIV_CYCLES), and operand/result holding registers.
REQ-015 In IDLE with start=1 and op=0/1, the block SHALL latch A, B and the signedness at the edge, load the counter with MULT_CYCLES, and go to MUL.
REQ-016 In IDLE with start=1 and op=2/3, the block SHALL latch operands and signedness, load the counter with DIV_CYCLES, and go to DIV.
REQ-017 In IDLE with start=1 and op=4 (mthi) or op=5 (mtlo), the block SHALL write A to HI or LO respectively at that edge, stay in IDLE, and never assert busy.
REQ-018 In IDLE with start=1 and op=6 or 7, the block SHALL perform no operation and change no state.
REQ-019 busy SHALL be 1 exactly when the state is MUL or DIV: N cycles after the accepting edge, where N = MULT_CYCLES or DIV_CYCLES.
REQ-020 In MUL or DIV, the counter SHALL decrement each edge; at the edge where it reaches 0, the block SHALL write HI/LO, return to IDLE, and deassert busy.
REQ-021 After that final edge, the new HI/LO SHALL be visible in the first cycle in which busy=0.
REQ-022 Multiply SHALL produce a 64-bit product, signed (mult) or unsigned (multu); HI = product[63:32], LO = product[31:0].
REQ-023 Divide SHALL set LO to the quotient (truncated toward zero) and HI to the remainder (sign of dividend for div; unsigned for divu).
REQ-024 Divide by B=0 SHALL still occupy DIV_CYCLES of busy time and SHALL leave HI/LO unchanged.
REQ-025 start while busy=1 SHALL be ignored: no operand latch, no HI/LO write, no counter reload.
REQ-026 md_stall SHALL be combinational: md_stall = md_use_D AND (start OR busy).
REQ-027 HI/LO SHALL change only on a REQ-017 write or REQ-020 completion.
REQ-028 A start accepted in the same cycle as a completion edge SHALL be impossible, because start is accepted only in IDLE.

Reset
REQ-029 On rst=1, regardless of clk, the block SHALL set state=IDLE, counter=0, busy=0, HI=0, LO=0, and clear the operand registers.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no HI/LO update.
REQ-031 md_stall SHALL be 0 during reset unless start and md_use_D are both driven high.

Verification
REQ-032 The bench SHALL drive mult with A=0xFFFFFFFD, B=5, and SHALL check busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-033 The bench SHALL drive divu with A=100, B=7, and SHALL check busy=1 for 10 cycles, then LO=0x0000000E, HI=0x00000002.
REQ-034 The bench SHALL drive div with A=0xFFFFFFF9 (-7), B=2, and SHALL check LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-035 The bench SHALL preload HI=0x11, LO=0x22 via mthi/mtlo, drive div with B=0, and SHALL check busy for 10 cycles with HI=0x11, LO=0x22 unchanged.
REQ-036 The bench SHALL drive multu 3x4 and, at cycle 2 of busy, drive start with mtlo A=0x55; it SHALL check the mtlo is ignored, LO=12, HI=0, and md_stall=1 whenever md_use_D=1 during busy.
REQ-037 The bench SHALL start divu 100/7, assert rst at busy cycle 4, and SHALL check immediate busy=0, HI=0, LO=0, state IDLE; a following mult 2x3 SHALL give LO=6.
